// File: rtl/uart2wifi_core_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart2wifi_core_uart_tx
// Brief    : FIFO-buffered UART transmitter, 8N1 by default; define
//            UART2WIFI_TX_PARITY_EN for an 8E1 frame with an even-parity bit.
// Revision : 1.0
// ============================================================================
module uart2wifi_core_uart_tx #(
  parameter int CLKS_PER_TICK = 163,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wr,
  input  logic [7:0] write_data,
  output logic       tx,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);

`ifdef UART2WIFI_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [3:0]          os_q, os_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
`ifdef UART2WIFI_TX_PARITY_EN
  logic                par_q, par_d;
`endif
  logic                tx_q, tx_d;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [PTR_W:0]      count_q;

  logic                w_wr_accept;
  logic                w_pop;
  logic                w_tick_end;
  logic                w_bit_end;
  logic [7:0]          w_head;

  assign tx_full     = (count_q == FULL_CNT);
  assign tx_empty    = (count_q == '0);
  assign w_wr_accept = tx_wr & ~tx_full;
  assign w_head      = mem_q[rptr_q];
  assign w_tick_end  = (tick_q == TICK_LAST);
  assign w_bit_end   = w_tick_end && (os_q == 4'd15);

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_wr_accept) wptr_q <= wptr_q + PTR_W'(1);
      if (w_pop)       rptr_q <= rptr_q + PTR_W'(1);
      case ({w_wr_accept, w_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_accept) mem_q[wptr_q] <= write_data;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART2WIFI_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART2WIFI_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    w_pop   = 1'b0;
`ifdef UART2WIFI_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Divider free-runs in every active state so bit boundaries stay exactly 16 ticks apart.
    if (state_q != S_IDLE) begin
      tick_d = w_tick_end ? '0 : tick_q + TICK_W'(1);
      if (w_tick_end) os_d = os_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
`ifdef UART2WIFI_TX_PARITY_EN
          par_d   = ^w_head;
`endif
          tick_d  = '0;
          os_d    = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART2WIFI_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART2WIFI_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (!tx_empty) begin
            w_pop   = 1'b1;
            shift_d = w_head;
`ifdef UART2WIFI_TX_PARITY_EN
            par_d   = ^w_head;
`endif
            bit_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------- outputs
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART2WIFI_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // Status flags share the line's one-cycle lag so done/busy line up with the stop bit on tx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= (state_q != S_IDLE);
      done_q <= (state_q == S_STOP) && w_bit_end;
      ovf_q  <= tx_wr && tx_full;
    end
  end

  assign tx          = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart2wifi_core_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart2wifi_core_uart_tx
// Brief    : Randomised self-checking bench: frame-timing reference model plus
//            a mid-bit sampling receiver. Honours UART2WIFI_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module tb_uart2wifi_core_uart_tx;

  localparam int CPT   = 4;
  localparam int DEPTH = 4;
  localparam int B     = 16 * CPT;
`ifdef UART2WIFI_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int F     = NB * B;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_wr = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       tx, tx_full, tx_empty, tx_busy, tx_done, tx_overflow;

  uart2wifi_core_uart_tx #(
    .CLKS_PER_TICK(CPT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_wr      (tx_wr),
    .write_data (write_data),
    .tx         (tx),
    .tx_full    (tx_full),
    .tx_empty   (tx_empty),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending bytes and the edge at which the current frame began.
  int         k = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_log[$];
  logic       rx_plog[$];
  bit         act = 1'b0;
  int         s = 0;
  logic [7:0] cur = 8'h00;
  int         done_cnt = 0, last_done = 0, done_gap = 0, ovf_cnt = 0;
  int         acc_cnt = 0, lost_cnt = 0;
  int         m_c, m_bi, m_pre;
  logic       e_tx, e_busy, e_done, e_ovf, e_full, e_empty;

  always begin
    @(posedge clk);
    k++;
    if (rst) begin
      lost_cnt += exp_rx.size();
      mq.delete();
      exp_rx.delete();
      act = 1'b0;
    end else begin
      e_tx   = 1'b1;
      e_done = 1'b0;
      e_busy = act;
      if (act) begin
        m_c  = k - 1 - s;
        m_bi = m_c / B;
        if (m_bi == 0)           e_tx = 1'b0;
        else if (m_bi <= 8)      e_tx = cur[m_bi-1];
        else if (m_bi == NB - 1) e_tx = 1'b1;
        else                     e_tx = ^cur;
        e_done = (m_c == F - 1);
      end
      m_pre = mq.size();
      e_ovf = tx_wr && (m_pre == DEPTH);
      if (act && k == s + F) act = 1'b0;
      if (!act && m_pre > 0) begin
        cur = mq.pop_front();
        s   = k;
        act = 1'b1;
      end
      if (tx_wr && m_pre < DEPTH) begin
        mq.push_back(write_data);
        exp_rx.push_back(write_data);
        acc_cnt++;
      end
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      #1;
      check_val("cycle{tx,busy,done,ovf,full,empty}",
                {tx, tx_busy, tx_done, tx_overflow, tx_full, tx_empty},
                {e_tx, e_busy, e_done, e_ovf, e_full, e_empty});
      if (tx_done) begin
        done_cnt++;
        done_gap  = k - last_done;
        last_done = k;
      end
      if (tx_overflow) ovf_cnt++;
    end
  end

  // Line receiver: samples each bit in its middle, independent of the model's timing.
  int         rx_cnt = 0;
  bit         rx_busy = 1'b0;
  bit         rx_abort = 1'b0;
  logic       rx_s, rx_stop;
  logic [7:0] rx_b, rx_e;
`ifdef UART2WIFI_TX_PARITY_EN
  logic       rx_p;
`endif

  task automatic rx_wait(input int n);
    for (int i = 0; i < n && !rx_abort; i++) begin
      @(posedge clk);
      if (rst) rx_abort = 1'b1;
    end
    #1;
  endtask

  always begin
    @(negedge tx);
    if (!rst) begin
      rx_busy  = 1'b1;
      rx_abort = 1'b0;
      rx_wait(B / 2);
      rx_s = tx;
      for (int i = 0; i < 8; i++) begin
        rx_wait(B);
        rx_b[i] = tx;
      end
`ifdef UART2WIFI_TX_PARITY_EN
      rx_wait(B);
      rx_p = tx;
`endif
      rx_wait(B);
      rx_stop = tx;
      if (!rx_abort) begin
        check_val("rx_start", rx_s, 0);
        check_val("rx_stop", rx_stop, 1);
        if (exp_rx.size() > 0) begin
          rx_e = exp_rx.pop_front();
          check_val("rx_byte", rx_b, rx_e);
`ifdef UART2WIFI_TX_PARITY_EN
          check_val("rx_parity", rx_p, ^rx_e);
          rx_plog.push_back(rx_p);
`endif
        end else begin
          check_val("rx_unexpected_frame", 1, 0);
        end
        rx_log.push_back(rx_b);
        rx_cnt++;
      end
      rx_busy = 1'b0;
    end
  end

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    tx_wr      = 1'b1;
    write_data = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (4) @(negedge clk);
    while ((tx_busy || !tx_empty || rx_busy) && n < 20 * F) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", (n < 20 * F), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n0, n_edge, fall, n;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_full", tx_full, 0);
    check_val("rst_empty", tx_empty, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_overflow", tx_overflow, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: latency, frame length, one done pulse
    n0 = done_cnt;
    wr(8'h61);
    n_edge = k + 1;
    @(negedge clk);
    tx_wr = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    fall = k;
    check_val("t1_fall_edge", fall, n_edge + 2);
    wait_idle();
    check_val("t1_done_count", done_cnt - n0, 1);
    check_val("t1_frame_len", last_done - fall + 1, F);
    check_val("t1_busy", tx_busy, 0);
    check_val("t1_byte", rx_log[rx_log.size()-1], 8'h61);

    // Back-to-back frames
    n0 = done_cnt;
    wr(8'h86);
    wr(8'hFA);
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle();
    check_val("t2_done_count", done_cnt - n0, 2);
    check_val("t2_done_gap", done_gap, F);
    check_val("t2_byte0", rx_log[rx_log.size()-2], 8'h86);
    check_val("t2_byte1", rx_log[rx_log.size()-1], 8'hFA);

    // Overflow: six writes into a depth-4 FIFO with the first popped at once
    n0 = ovf_cnt;
    for (int i = 1; i <= 6; i++) wr(8'(i));
    @(negedge clk);
    tx_wr = 1'b0;
    check_val("t3_full", tx_full, 1);
    check_val("t3_overflow_pulse", tx_overflow, 1);
    wait_idle();
    check_val("t3_overflow_count", ovf_cnt - n0, 1);
    for (int i = 0; i < 5; i++)
      check_val("t3_byte", rx_log[rx_log.size()-5+i], i + 1);

    // Reset during data bit 3 of 0xA5
    wr(8'hA5);
    @(negedge clk);
    tx_wr = 1'b0;
    repeat (2 + 4 * B + B / 2) @(negedge clk);
    check_val("t4_bit3", tx, 0);
    #2 rst = 1'b1;
    #1;
    check_val("t4_rst_tx", tx, 1);
    check_val("t4_rst_empty", tx_empty, 1);
    check_val("t4_rst_busy", tx_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr(8'h3C);
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle();
    check_val("t4_byte", rx_log[rx_log.size()-1], 8'h3C);

`ifdef UART2WIFI_TX_PARITY_EN
    wr(8'h61);
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle();
    check_val("t6_parity_61", rx_plog[rx_plog.size()-1], 1);
    wr(8'h03);
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle();
    check_val("t6_parity_03", rx_plog[rx_plog.size()-1], 0);
`endif

    // Random writes, frequently ignoring tx_full
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      tx_wr      = ($urandom_range(0, 99) < 2);
      write_data = 8'($urandom);
    end
    @(negedge clk);
    tx_wr = 1'b0;
    wait_idle();

    check_val("rx_frame_count", rx_cnt, acc_cnt - lost_cnt);
    check_val("rx_pending", exp_rx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
